// File: rtl/div_seq_ctrl_pkg.sv
// Shared definitions for the sequential divider controller: op encodings,
// the one-hot FSM state type and small op-decoding helpers.
package div_seq_ctrl_pkg;

  // Bit 1 selects unsigned, bit 0 selects remainder instead of quotient.
  localparam logic [1:0] DIV_OP_DIV_W  = 2'b00;
  localparam logic [1:0] DIV_OP_MOD_W  = 2'b01;
  localparam logic [1:0] DIV_OP_DIV_WU = 2'b10;
  localparam logic [1:0] DIV_OP_MOD_WU = 2'b11;

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    CALC = 4'b0010,
    FIX  = 4'b0100,
    DONE = 4'b1000
  } div_state_t;

  // True for the two's-complement (.w) ops.
  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == DIV_OP_DIV_W) || (op == DIV_OP_MOD_W);
  endfunction

  // True when the op returns the remainder.
  function automatic logic op_is_mod(input logic [1:0] op);
    return (op == DIV_OP_MOD_W) || (op == DIV_OP_MOD_WU);
  endfunction

endpackage

// File: rtl/div_seq_ctrl_if.sv
// EX-stage <-> divider handshake bundle: request channel, response channel,
// flush and busy status.
interface div_seq_ctrl_if #(
  parameter int DATA_W = 32
) ();

  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [DATA_W-1:0] req_src1;
  logic [DATA_W-1:0] req_src2;
  logic              flush;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_result;
  logic              busy;

  // EX stage side.
  modport master (
    output req_valid, req_op, req_src1, req_src2, flush, resp_ready,
    input  req_ready, resp_valid, resp_result, busy
  );

  // Divider controller side.
  modport slave (
    input  req_valid, req_op, req_src1, req_src2, flush, resp_ready,
    output req_ready, resp_valid, resp_result, busy
  );

endinterface

// File: rtl/div_seq_ctrl_iter_step.sv
// One restoring shift-subtract step on unsigned magnitudes. The shifted
// partial remainder is kept one bit wider than DATA_W so that divisors with
// the MSB set (unsigned ops) never lose the bit shifted out of rem.
module div_iter_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem,
  input  logic              quo_msb,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_next,
  output logic              q_bit
);

  logic [DATA_W:0] shifted_s;
  logic [DATA_W:0] diff_s;

  // Trial subtraction; a clear sign bit means the divisor fits.
  always_comb begin
    shifted_s = {rem, quo_msb};
    diff_s    = shifted_s - {1'b0, divisor};
    q_bit     = ~diff_s[DATA_W];
    if (q_bit) begin
      rem_next = diff_s[DATA_W-1:0];
    end else begin
      rem_next = shifted_s[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequencer for the EX-stage multi-cycle divider: accepts one op, runs
// DATA_W restoring iterations on operand magnitudes, applies sign fix-up and
// holds the result until EX consumes it. flush returns to IDLE from anywhere.
module div_seq_ctrl
  import div_seq_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          resetn,
  div_seq_ctrl_if.slave bus
);

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] ZERO_W = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] ONES_W = {DATA_W{1'b1}};

  // Two's-complement negate when cond is set.
  function automatic logic [DATA_W-1:0] neg_if(input logic cond, input logic [DATA_W-1:0] v);
    return cond ? (~v + DATA_W'(1)) : v;
  endfunction

  div_state_t        state_r;
  div_state_t        state_nxt_s;
  logic [CNT_W-1:0]  counter_r;
  logic [1:0]        op_r;
  logic              sign1_r;
  logic              sign2_r;
  logic [DATA_W-1:0] quo_r;
  logic [DATA_W-1:0] dvs_r;
  logic [DATA_W-1:0] rem_r;
  logic [DATA_W-1:0] result_r;

  logic              accept_s;
  logic              neg1_s;
  logic              neg2_s;
  logic [DATA_W-1:0] rem_next_s;
  logic              q_bit_s;
  logic [DATA_W-1:0] quo_fix_s;
  logic [DATA_W-1:0] rem_fix_s;
  logic [DATA_W-1:0] fix_result_s;
  logic              req_ready_s;
  logic              resp_valid_s;
  logic              busy_s;

  assign accept_s = bus.req_valid & (state_r == IDLE) & ~bus.flush;
  assign neg1_s   = op_is_signed(bus.req_op) & bus.req_src1[DATA_W-1];
  assign neg2_s   = op_is_signed(bus.req_op) & bus.req_src2[DATA_W-1];

  div_iter_step #(.DATA_W(DATA_W)) u_step (
    .rem      (rem_r),
    .quo_msb  (quo_r[DATA_W-1]),
    .divisor  (dvs_r),
    .rem_next (rem_next_s),
    .q_bit    (q_bit_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    state_nxt_s = state_r;
    if (bus.flush) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req_valid) begin
            state_nxt_s = (bus.req_src2 == ZERO_W) ? FIX : CALC;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        CALC: begin
          if (counter_r == CNT_LAST) begin
            state_nxt_s = FIX;
          end else begin
            state_nxt_s = CALC;
          end
        end
        FIX:  state_nxt_s = DONE;
        DONE: begin
          if (bus.resp_ready) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = DONE;
          end
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Handshake/status outputs decoded straight from the one-hot state register.
  always_comb begin
    req_ready_s  = 1'b0;
    resp_valid_s = 1'b0;
    busy_s       = 1'b1;
    case (state_r)
      IDLE: begin
        req_ready_s = 1'b1;
        busy_s      = 1'b0;
      end
      CALC:    busy_s = 1'b1;
      FIX:     busy_s = 1'b1;
      DONE:    resp_valid_s = 1'b1;
      default: busy_s = 1'b1;
    endcase
  end

  assign bus.req_ready   = req_ready_s;
  assign bus.resp_valid  = resp_valid_s;
  assign bus.busy        = busy_s;
  assign bus.resp_result = result_r;

  // Iteration counter: restarts on accept/flush, wraps to 0 on the last step.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      counter_r <= {CNT_W{1'b0}};
    end else if (bus.flush || accept_s) begin
      counter_r <= {CNT_W{1'b0}};
    end else if (state_r == CALC) begin
      counter_r <= counter_r + CNT_W'(1);
    end else begin
      counter_r <= counter_r;
    end
  end

  // Operand/sign latches on accept, then the shift-subtract datapath in CALC.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      op_r    <= DIV_OP_DIV_W;
      sign1_r <= 1'b0;
      sign2_r <= 1'b0;
      quo_r   <= ZERO_W;
      dvs_r   <= ZERO_W;
      rem_r   <= ZERO_W;
    end else if (accept_s) begin
      op_r    <= bus.req_op;
      sign1_r <= neg1_s;
      sign2_r <= neg2_s;
      quo_r   <= neg_if(neg1_s, bus.req_src1);
      dvs_r   <= neg_if(neg2_s, bus.req_src2);
      rem_r   <= ZERO_W;
    end else if ((state_r == CALC) && !bus.flush) begin
      rem_r   <= rem_next_s;
      quo_r   <= {quo_r[DATA_W-2:0], q_bit_s};
    end else begin
      rem_r   <= rem_r;
      quo_r   <= quo_r;
    end
  end

  // Sign fix-up. With a zero divisor quo_r still holds |src1|, so re-applying
  // the dividend sign restores src1 unmodified for the remainder.
  always_comb begin
    quo_fix_s = neg_if(sign1_r ^ sign2_r, quo_r);
    rem_fix_s = neg_if(sign1_r, rem_r);
    if (dvs_r == ZERO_W) begin
      quo_fix_s = ONES_W;
      rem_fix_s = neg_if(sign1_r, quo_r);
    end else begin
      quo_fix_s = neg_if(sign1_r ^ sign2_r, quo_r);
      rem_fix_s = neg_if(sign1_r, rem_r);
    end
    if (op_is_mod(op_r)) begin
      fix_result_s = rem_fix_s;
    end else begin
      fix_result_s = quo_fix_s;
    end
  end

  // Result register: loaded in FIX, held through DONE and IDLE.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      result_r <= ZERO_W;
    end else if ((state_r == FIX) && !bus.flush) begin
      result_r <= fix_result_s;
    end else begin
      result_r <= result_r;
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: directed cases plus randomized ops
// compared against an arithmetic reference model.
module tb_div_seq_ctrl;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  div_seq_ctrl_if #(.DATA_W(32)) bus ();

  div_seq_ctrl #(.DATA_W(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; INT_MIN/-1 truncates to 0x80000000.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0) return op[0] ? a : 32'hFFFF_FFFF;
    if (!op[1]) return op[0] ? 32'(sa % sb) : 32'(sa / sb);
    return op[0] ? (a % b) : (a / b);
  endfunction

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input string tag);
    int n;
    logic [31:0] exp;
    exp = ref_div(op, a, b);
    @(negedge clk);
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_src1  = a;
    bus.req_src2  = b;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    n = 0;
    while (bus.resp_valid !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 32'(n), (b == 32'd0) ? 32'd1 : 32'd33);
    chk({tag, "_res"}, bus.resp_result, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_st"}, {29'd0, bus.resp_valid, bus.busy, bus.req_ready}, 32'b110);
      chk({tag, "_hold_res"}, bus.resp_result, exp);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    chk({tag, "_idle"}, {30'd0, bus.resp_valid, bus.req_ready}, 32'b01);
  endtask

  initial begin
    int seen;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    bus.req_valid  = 1'b0;
    bus.req_op     = 2'b00;
    bus.req_src1   = 32'd0;
    bus.req_src2   = 32'd0;
    bus.flush      = 1'b0;
    bus.resp_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {29'd0, bus.req_ready, bus.resp_valid, bus.busy}, 32'b100);
    chk("rst_res", bus.resp_result, 32'd0);
    resetn = 1'b1;

    // Directed cases
    do_op(2'b00, 32'd7, 32'hFFFF_FFFE, 0, "t1_divw");
    chk("t1_val", bus.resp_result, 32'hFFFF_FFFD);
    do_op(2'b01, 32'hFFFF_FFF9, 32'd2, 0, "t2_modw_a");
    chk("t2_val_a", bus.resp_result, 32'hFFFF_FFFF);
    do_op(2'b01, 32'd7, 32'hFFFF_FFFE, 0, "t2_modw_b");
    chk("t2_val_b", bus.resp_result, 32'h0000_0001);
    do_op(2'b10, 32'hFFFF_FFFF, 32'h10, 0, "t3_divwu");
    chk("t3_val_a", bus.resp_result, 32'h0FFF_FFFF);
    do_op(2'b11, 32'hFFFF_FFFF, 32'h10, 0, "t3_modwu");
    chk("t3_val_b", bus.resp_result, 32'h0000_000F);
    do_op(2'b00, 32'd5, 32'd0, 0, "t4_divz");
    chk("t4_val_a", bus.resp_result, 32'hFFFF_FFFF);
    do_op(2'b01, 32'd5, 32'd0, 0, "t4_modz");
    chk("t4_val_b", bus.resp_result, 32'h0000_0005);
    do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, "t5_ovf_div");
    chk("t5_val_a", bus.resp_result, 32'h8000_0000);
    do_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 0, "t5_ovf_mod");
    chk("t5_val_b", bus.resp_result, 32'h0000_0000);

    // Flush on the 10th CALC edge
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b00;
    bus.req_src1  = 32'd1000;
    bus.req_src2  = 32'd3;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("t6_flush_ready", {30'd0, bus.req_ready, bus.busy}, 32'b10);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1) seen++;
    end
    chk("t6_no_resp", 32'(seen), 32'd0);
    do_op(2'b10, 32'd100, 32'd7, 5, "t6_after");
    chk("t6_val", bus.resp_result, 32'd14);

    // flush together with req_valid in IDLE: not accepted
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.flush     = 1'b1;
    bus.req_src1  = 32'd9;
    bus.req_src2  = 32'd2;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    repeat (3) @(negedge clk);
    chk("flush_idle", {29'd0, bus.req_ready, bus.resp_valid, bus.busy}, 32'b100);

    // Randomized ops against the reference model
    for (int k = 0; k < 24; k++) begin
      rop = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: ra = 32'h8000_0000;
        1: ra = 32'($urandom_range(0, 200)) - 32'd100;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(0, 18)) - 32'd9;
        default: rb = $urandom;
      endcase
      do_op(rop, ra, rb, $urandom_range(0, 2), "rnd");
    end

    // Reset asserted mid-CALC
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b00;
    bus.req_src1  = 32'd12345;
    bus.req_src2  = 32'd7;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk("t7_rst_ctrl", {29'd0, bus.req_ready, bus.resp_valid, bus.busy}, 32'b100);
    chk("t7_rst_res", bus.resp_result, 32'd0);
    resetn = 1'b1;
    do_op(2'b11, 32'd12345, 32'd7, 1, "t7_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
